// File: rtl/mem_arbiter.sv
// Two-requester (core/debug) memory arbiter with debug starvation guard and bus lock.
// Checks access alignment and returns one-cycle responses with registered read data.
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        c_req,
   input  logic        c_we,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic [2:0]  c_type,
   output logic        c_gnt,
   output logic        c_rvalid,
   output logic        c_err,
   output logic [31:0] c_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic        d_lock,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_type,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        m_store,
   output logic [31:0] m_direccion,
   output logic [31:0] m_store_data,
   output logic [31:0] m_offset,
   output logic [2:0]  m_type,
   input  logic [31:0] m_load_data
);

   localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   typedef enum logic {
      NORMAL   = 1'b0,
      DBG_LOCK = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_cnt_nxt;
   logic             acc_illegal;

   // Misaligned halfword/word accesses and the reserved size code are rejected.
   function automatic logic is_illegal(input logic [2:0] t, input logic [1:0] a);
      logic bad;
      bad = 1'b0;
      case (t[1:0])
         2'b01:   bad = a[0];
         2'b10:   bad = (a != 2'b00);
         2'b11:   bad = 1'b1;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= NORMAL;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt      = state;
      starve_cnt_nxt = starve_cnt;
      if (!d_req || d_gnt) begin
         starve_cnt_nxt = '0;
      end else if (c_gnt && (starve_cnt != CNT_MAX)) begin
         starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
      case (state)
         NORMAL: begin
            if (d_gnt && d_lock) state_nxt = DBG_LOCK;
         end
         DBG_LOCK: begin
            if (!d_req || (d_gnt && !d_lock)) state_nxt = NORMAL;
         end
         default: state_nxt = NORMAL;
      endcase
   end

   // Grant and memory-port outputs
   always_comb begin
      c_gnt        = 1'b0;
      d_gnt        = 1'b0;
      m_store      = 1'b0;
      m_offset     = 32'h0;
      m_direccion  = c_addr;
      m_store_data = c_wdata;
      m_type       = c_type;
      acc_illegal  = is_illegal(c_type, c_addr[1:0]);
      if (rst_n) begin
         case (state)
            NORMAL: begin
               if (c_req && (starve_cnt < CNT_MAX)) c_gnt = 1'b1;
               else if (d_req)                      d_gnt = 1'b1;
            end
            DBG_LOCK: d_gnt = d_req;
            default: begin
               c_gnt = 1'b0;
               d_gnt = 1'b0;
            end
         endcase
      end
      if (d_gnt) begin
         m_direccion  = d_addr;
         m_store_data = d_wdata;
         m_type       = d_type;
         acc_illegal  = is_illegal(d_type, d_addr[1:0]);
      end
      m_store = !acc_illegal && ((c_gnt && c_we) || (d_gnt && d_we));
   end

   // Response registers: one-cycle rvalid, err and zeroed data on illegal access
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         c_rvalid <= 1'b0;
         c_err    <= 1'b0;
         c_rdata  <= 32'h0;
         d_rvalid <= 1'b0;
         d_err    <= 1'b0;
         d_rdata  <= 32'h0;
      end else begin
         c_rvalid <= c_gnt;
         c_err    <= c_gnt && acc_illegal;
         d_rvalid <= d_gnt;
         d_err    <= d_gnt && acc_illegal;
         if (c_gnt) begin
            if (acc_illegal)  c_rdata <= 32'h0;
            else if (!c_we)   c_rdata <= m_load_data;
         end
         if (d_gnt) begin
            if (acc_illegal)  d_rdata <= 32'h0;
            else if (!d_we)   d_rdata <= m_load_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: word-array memory, cycle-level reference model and directed checks.
module tb_mem_arbiter;

   localparam int unsigned STARVE = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        c_req, c_we, d_req, d_we, d_lock;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic [2:0]  c_type, d_type;
   logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err, m_store;
   logic [31:0] c_rdata, d_rdata, m_direccion, m_store_data, m_offset, m_load_data;
   logic [2:0]  m_type;

   logic [31:0] mem [0:15];
   int          vectors = 0;
   int          miscompares = 0;

   mem_arbiter #(.STARVE_MAX(STARVE)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_type(c_type),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_err(c_err), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_type(d_type), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
      .m_store(m_store), .m_direccion(m_direccion), .m_store_data(m_store_data),
      .m_offset(m_offset), .m_type(m_type), .m_load_data(m_load_data)
   );

   always #5 clk = ~clk;

   // Simple word memory behind the arbiter
   assign m_load_data = mem[m_direccion[5:2]];
   always @(posedge clk) if (m_store) mem[m_direccion[5:2]] <= m_store_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Access must be naturally aligned to its size; size code 3 is reserved
   function automatic bit bad_access(input logic [2:0] t, input logic [31:0] a);
      int unsigned size;
      if (t[1:0] == 2'b11) return 1'b1;
      size = 32'd1 << t[1:0];
      return (a % size) != 0;
   endfunction

   // Reference model
   bit          chk_en = 1'b0;
   bit          locked = 1'b0;
   int unsigned core_run = 0;
   logic        e_c_rvalid, e_c_err, e_d_rvalid, e_d_err;
   logic [31:0] e_c_rdata, e_d_rdata;

   always @(negedge clk) begin
      bit          gc, gd, bad, we;
      logic [31:0] a, wd;
      logic [2:0]  t;
      if (chk_en) begin
         chk("c_rvalid", 32'(c_rvalid), 32'(e_c_rvalid));
         chk("c_err",    32'(c_err),    32'(e_c_err));
         chk("c_rdata",  c_rdata,       e_c_rdata);
         chk("d_rvalid", 32'(d_rvalid), 32'(e_d_rvalid));
         chk("d_err",    32'(d_err),    32'(e_d_err));
         chk("d_rdata",  d_rdata,       e_d_rdata);
      end
      gc = 1'b0;
      gd = 1'b0;
      if (rst_n) begin
         if (locked) gd = d_req;
         else begin
            gc = c_req && (core_run < STARVE);
            gd = !gc && d_req;
         end
      end
      a  = gd ? d_addr : c_addr;
      wd = gd ? d_wdata : c_wdata;
      t  = gd ? d_type : c_type;
      we = gd ? d_we : c_we;
      bad = bad_access(t, a);
      if (chk_en || !rst_n) begin
         chk("c_gnt",   32'(c_gnt),   32'(gc));
         chk("d_gnt",   32'(d_gnt),   32'(gd));
         chk("m_store", 32'(m_store), 32'((gc || gd) && we && !bad));
         chk("m_offset", m_offset, 32'h0);
         if (gc || gd) begin
            chk("m_direccion",  m_direccion, a);
            chk("m_type",       32'(m_type), 32'(t));
            chk("m_store_data", m_store_data, wd);
         end
      end
      if (!rst_n) begin
         chk_en = 1'b1;
         locked = 1'b0;
         core_run = 0;
         {e_c_rvalid, e_c_err, e_d_rvalid, e_d_err} = 4'b0;
         e_c_rdata = 32'h0;
         e_d_rdata = 32'h0;
      end else if (chk_en) begin
         e_c_rvalid = gc;
         e_d_rvalid = gd;
         e_c_err    = gc && bad;
         e_d_err    = gd && bad;
         if (gc && bad) e_c_rdata = 32'h0;
         else if (gc && !we) e_c_rdata = mem[a[5:2]];
         if (gd && bad) e_d_rdata = 32'h0;
         else if (gd && !we) e_d_rdata = mem[a[5:2]];
         if (!d_req || gd) core_run = 0;
         else if (gc && core_run < STARVE) core_run++;
         if (gd && d_lock) locked = 1'b1;
         else if (!d_req || (gd && !d_lock)) locked = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_c(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] t);
      c_req = req; c_we = we; c_addr = a; c_wdata = wd; c_type = t;
   endtask

   task automatic set_d(input logic req, input logic we, input logic lock, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] t);
      d_req = req; d_we = we; d_lock = lock; d_addr = a; d_wdata = wd; d_type = t;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      rst_n = 1'b0;
      set_c(0, 0, 0, 0, 3'b010);
      set_d(0, 0, 0, 0, 0, 3'b010);
      step();
      step();
      chk("rst_c_rvalid", 32'(c_rvalid), 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      rst_n = 1'b1;

      // Core SW then LW at address 0
      set_c(1, 1, 32'h0, 32'h37, 3'b010);
      #1 chk("sw_store", 32'(m_store), 32'h1);
      step();
      chk("sw_rvalid", 32'(c_rvalid), 32'h1);
      set_c(1, 0, 32'h0, 32'h0, 3'b010);
      #1 chk("lw_nostore", 32'(m_store), 32'h0);
      step();
      chk("lw_rvalid", 32'(c_rvalid), 32'h1);
      chk("lw_rdata", c_rdata, 32'h37);
      chk("lw_err", 32'(c_err), 32'h0);

      // Debug SW at 4 to seed data for later debug reads
      set_c(0, 0, 0, 0, 3'b010);
      set_d(1, 1, 0, 32'h4, 32'hA5, 3'b010);
      step();
      chk("dsw_rvalid", 32'(d_rvalid), 32'h1);

      // Contention: C,C,C,C,D repeating
      set_c(1, 0, 32'h0, 32'h0, 3'b010);
      set_d(1, 0, 0, 32'h4, 32'h0, 3'b010);
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("pat_c", 32'(c_gnt), 32'((i % 5) < 4));
         chk("pat_d", 32'(d_gnt), 32'((i % 5) == 4));
         step();
      end
      chk("pat_d_rdata", d_rdata, 32'hA5);

      // Debug lock holds off the core
      set_c(0, 0, 0, 0, 3'b010);
      set_d(0, 0, 0, 0, 0, 3'b010);
      step();
      set_d(1, 0, 1, 32'h4, 32'h0, 3'b010);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) c_req = 1'b1;
         if (i == 3) d_lock = 1'b0;
         #1;
         chk("lock_c", 32'(c_gnt), 32'h0);
         chk("lock_d", 32'(d_gnt), 32'h1);
         step();
      end
      #1 chk("unlock_c", 32'(c_gnt), 32'h1);
      step();

      // Misaligned core accesses
      set_d(0, 0, 0, 0, 0, 3'b010);
      set_c(1, 0, 32'h0, 32'h0, 3'b010);
      step();
      chk("pre_rdata", c_rdata, 32'h37);
      set_c(1, 0, 32'h2, 32'h0, 3'b010);
      step();
      chk("lw2_err", 32'(c_err), 32'h1);
      chk("lw2_rdata", c_rdata, 32'h0);
      set_c(1, 1, 32'h5, 32'h99, 3'b001);
      #1 chk("sh5_nostore", 32'(m_store), 32'h0);
      step();
      chk("sh5_err", 32'(c_err), 32'h1);
      chk("sh5_rvalid", 32'(c_rvalid), 32'h1);

      // Reset in the middle of a debug lock
      set_c(0, 0, 0, 0, 3'b010);
      set_d(1, 0, 1, 32'h4, 32'h0, 3'b010);
      step();
      c_req = 1'b1;
      step();
      rst_n = 1'b0;
      #1;
      chk("rstlk_c", 32'(c_gnt), 32'h0);
      chk("rstlk_d", 32'(d_gnt), 32'h0);
      step();
      chk("rstlk_d_rvalid", 32'(d_rvalid), 32'h0);
      chk("rstlk_d_rdata", d_rdata, 32'h0);
      rst_n = 1'b1;
      #1 chk("rstlk_first_c", 32'(c_gnt), 32'h1);
      step();

      // Mixed traffic checked by the model only
      for (int i = 0; i < 60; i++) begin
         set_c(1'($urandom), 1'($urandom), 32'($urandom_range(0, 63)), $urandom, 3'($urandom));
         set_d(1'($urandom), 1'($urandom), 1'($urandom), 32'($urandom_range(0, 63)),
               $urandom, 3'($urandom));
         step();
      end
      set_c(0, 0, 0, 0, 3'b010);
      set_d(0, 0, 0, 0, 0, 3'b010);
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, the maximum number of consecutive core grants while a debug request waits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have ports c_req, c_we  input  1 each  core request and write-enable.
REQ-005 SHALL have ports c_addr, c_wdata  input  32 each, and c_type  input  3  (RISC-V funct3 width code).
REQ-006 SHALL have ports c_gnt  output  1, c_rvalid  output  1, c_err  output  1, and c_rdata  output  32.
REQ-007 SHALL have debug ports d_req, d_we, d_lock (input 1), d_addr, d_wdata (input 32), d_type (input 3), d_gnt, d_rvalid, d_err (output 1) and d_rdata (output 32).
REQ-008 SHALL have memory ports m_store (output 1), m_direccion, m_store_data, m_offset (output 32), m_type (output 3) and m_load_data (input 32).

Function
REQ-009 SHALL grant at most one requester per cycle; c_gnt and d_gnt are combinational and never both high.
REQ-010 SHALL keep requester inputs stable from req high until the cycle gnt is high; the access occurs in that grant cycle.
REQ-011 SHALL implement FSM states NORMAL and DBG_LOCK.
REQ-012 In NORMAL, SHALL grant the core when c_req=1 and starve_cnt<STARVE_MAX, otherwise grant debug if d_req=1.
REQ-013 SHALL increment starve_cnt (saturating at STARVE_MAX) on every core grant while d_req=1, and SHALL clear it on any debug grant or any cycle with d_req=0.
REQ-014 SHALL move NORMAL->DBG_LOCK on a debug grant with d_lock=1.
REQ-015 In DBG_LOCK, SHALL grant only debug; c_gnt stays 0.
REQ-016 SHALL return DBG_LOCK->NORMAL on a debug grant with d_lock=0, or on any cycle with d_req=0.
REQ-017 SHALL drive m_direccion, m_store_data and m_type from the granted requester, and SHALL drive m_offset to constant 0.
REQ-018 SHALL assert m_store = granted requester's we only when the access is legal, and SHALL hold m_store=0 in any cycle without a grant.
REQ-019 SHALL classify an access illegal when type[1:0]=11, when type[1:0]=01 and addr[0]=1, or when type[1:0]=10 and addr[1:0]!=00.
REQ-020 SHALL set the granted side's rvalid to 1 for exactly the cycle after the grant, for both reads and writes.
REQ-021 For legal reads, SHALL register m_load_data into the granted side's rdata at the grant edge; rdata SHALL hold its value otherwise.
REQ-022 For writes, SHALL leave rdata unchanged.
REQ-023 For illegal accesses, SHALL set err=1 and rdata=0 with that rvalid; err SHALL be 0 whenever rvalid is 0 or the access was legal.
REQ-024 SHALL allow back-to-back grants every cycle, including alternating core/debug grants, with no bubble.

Reset
REQ-025 While rst_n=0 at a rising edge, SHALL set state to NORMAL, starve_cnt to 0, and all rvalid, err and rdata outputs to 0.
REQ-026 While rst_n=0, SHALL force c_gnt=0, d_gnt=0 and m_store=0.
REQ-027 Reset asserted during DBG_LOCK SHALL clear the lock; no response SHALL be produced for the access in the reset cycle.

Verification
REQ-028 Core SW addr 0, wdata 0x37, type 010, then LW addr 0 -> m_store=1 in cycle 1, c_rvalid in cycles 2 and 3, c_rdata=0x37 in cycle 3, c_err=0.
REQ-029 c_req and d_req held high continuously with STARVE_MAX=4 -> grant pattern C,C,C,C,D repeating; never two gnts in one cycle.
REQ-030 Debug access with d_lock=1 for 3 cycles, then d_lock=0, while c_req=1 -> c_gnt=0 for 4 cycles, then the core is granted.
REQ-031 Core LW at addr 0x2, and core SH at addr 0x5 -> no m_store, c_err=1, c_rdata=0 in the cycle after each.
REQ-032 rst_n=0 for one cycle mid-DBG_LOCK -> gnts 0 that cycle, all outputs 0, state NORMAL, and the core is granted first after release.
